// File: rtl/reg_sched_pkg.sv
// reg_sched_pkg: shared types and constants for the register write scheduler.
package reg_sched_pkg;

    // Which requester currently owns the write window.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        INT  = 2'd2
    } port_sel_e;

    // Legal range of CLK cycles per half-phase.
    localparam int unsigned DIV_MIN = 1;
    localparam int unsigned DIV_MAX = 8;

    // CPU wins (while the internal port waits) before the internal port is forced in.
    localparam logic [1:0] FAIR_THRESH = 2'd3;

endpackage

// File: rtl/reg_write_sched_phase_gen.sv
// phase_gen: phase counter pc (0..2*DIV-1), registered phi_keep and phase strobes.
// phi_keep is held at 1 while the bank is in its post-reset hold (hold=1).
module phase_gen
    import reg_sched_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic CLK,
    input  logic n_RES,
    input  logic hold,
    output logic phi_keep,
    output logic arb_edge,
    output logic win_last,
    output logic wrap
);

    localparam int unsigned DIV_C = (DIV < DIV_MIN) ? DIV_MIN :
                                    (DIV > DIV_MAX) ? DIV_MAX : DIV;
    localparam int unsigned PCW = $clog2(2 * DIV_C);
    localparam logic [PCW-1:0] PC_LAST = PCW'(2 * DIV_C - 1);
    localparam logic [PCW-1:0] PC_WEND = PCW'(DIV_C - 1);
    localparam logic [PCW-1:0] PC_KEEP = PCW'(DIV_C);

    logic [PCW-1:0] pc;
    logic [PCW-1:0] pc_next;

    // Arbitration happens on the wrap edge, so the two strobes coincide.
    assign wrap     = (pc == PC_LAST);
    assign arb_edge = wrap;
    assign win_last = !hold && (pc == PC_WEND);

    // Next phase count, wrapping after the keep half.
    always_comb begin
        pc_next = wrap ? '0 : pc + PCW'(1);
    end

    // Phase counter and phi_keep, registered so phi_keep tracks pc exactly.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            pc       <= '0;
            phi_keep <= 1'b1;
        end else begin
            pc       <= pc_next;
            phi_keep <= (hold && !wrap) ? 1'b1 : (pc_next >= PC_KEEP);
        end
    end

endmodule

// File: rtl/reg_write_sched.sv
// reg_write_sched: arbitrates CPU and internal write ports onto a bank of
// phase-keep register cells; drives phi_keep, one-hot reg_en, reg_d, reg_res.
// Optional macro REG_WRITE_SCHED_FAIR_EN: internal port is forced in after
// FAIR_THRESH consecutive contested CPU wins; otherwise strict CPU priority.
module reg_write_sched
    import reg_sched_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned DIV   = 2
) (
    input  logic             CLK,
    input  logic             n_RES,
    input  logic             cpu_req,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_data,
    output logic             cpu_ack,
    input  logic             int_req,
    input  logic [AW-1:0]    int_addr,
    input  logic [DW-1:0]    int_data,
    output logic             int_ack,
    output logic             phi_keep,
    output logic [NREGS-1:0] reg_en,
    output logic [DW-1:0]    reg_d,
    output logic             reg_res,
    output logic             addr_err
);

    logic arb_edge;
    logic win_last;
    logic wrap;
    logic fair_due;

    port_sel_e        gnt_sel;
    port_sel_e        gnt_nxt;
    logic             gnt_oor;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic [NREGS-1:0] sel_onehot;
    logic             sel_oor;

    phase_gen #(
        .DIV (DIV)
    ) u_phase (
        .CLK      (CLK),
        .n_RES    (n_RES),
        .hold     (reg_res),
        .phi_keep (phi_keep),
        .arb_edge (arb_edge),
        .win_last (win_last),
        .wrap     (wrap)
    );

    // Bank reset held until the first phase wrap after reset release.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            reg_res <= 1'b1;
        end else if (wrap) begin
            reg_res <= 1'b0;
        end
    end

`ifdef REG_WRITE_SCHED_FAIR_EN
    logic [1:0] fair_cnt;

    assign fair_due = (fair_cnt == FAIR_THRESH);

    // Count contested CPU wins; any internal grant restarts the count.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            fair_cnt <= '0;
        end else if (arb_edge) begin
            if (gnt_nxt == INT) begin
                fair_cnt <= '0;
            end else if (gnt_nxt == CPU && int_req) begin
                fair_cnt <= fair_cnt + 2'd1;
            end
        end
    end
`else
    assign fair_due = 1'b0;
`endif

    // Grant owner register.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            gnt_sel <= NONE;
        end else begin
            gnt_sel <= gnt_nxt;
        end
    end

    // Arbitrate on the wrap edge; release the grant after the last window cycle.
    always_comb begin
        gnt_nxt = gnt_sel;
        if (arb_edge) begin
            if (int_req && (!cpu_req || fair_due)) begin
                gnt_nxt = INT;
            end else if (cpu_req) begin
                gnt_nxt = CPU;
            end else begin
                gnt_nxt = NONE;
            end
        end else if (win_last) begin
            gnt_nxt = NONE;
        end
    end

    // Select the winning port's address/data and decode the load enable.
    always_comb begin
        sel_addr   = (gnt_nxt == INT) ? int_addr : cpu_addr;
        sel_data   = (gnt_nxt == INT) ? int_data : cpu_data;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (sel_addr == AW'(i)) begin
                sel_onehot[i] = 1'b1;
            end
        end
        sel_oor = (32'(sel_addr) >= NREGS);
    end

    // Latch the grant into the bank drive; reg_en spans exactly the window.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            reg_en  <= '0;
            reg_d   <= '0;
            gnt_oor <= 1'b0;
        end else if (arb_edge) begin
            if (gnt_nxt != NONE) begin
                reg_en  <= sel_onehot;
                reg_d   <= sel_data;
                gnt_oor <= sel_oor;
            end else begin
                reg_en  <= '0;
            end
        end else if (win_last) begin
            reg_en <= '0;
        end
    end

    assign cpu_ack  = win_last && (gnt_sel == CPU);
    assign int_ack  = win_last && (gnt_sel == INT);
    assign addr_err = win_last && (gnt_sel != NONE) && gnt_oor;

endmodule

// File: doc/reg_write_sched.md
# reg_write_sched

Write scheduler for a bank of phase-keep register cells (enable + keep-phase + reset flops). It generates the shared keep/write phase from the single clock, arbitrates two write requesters (external CPU bus port and internal sequencer port) onto the bank, and drives one-hot load enables, write data and bank reset. It sits between the bus/sequencer logic and any register bank built from such cells, for example APU or PPU control registers.

## Interface
- NREGS, 8 — number of register cells in the bank
- AW, 3 — address width; must satisfy 2^AW >= NREGS
- DW, 8 — data width
- DIV, 2 — CLK cycles per half-phase; legal range 1..8
- CLK  in  1  — single clock; all state on rising edge
- n_RES  in  1  — asynchronous, active-low reset
- cpu_req  in  1  — CPU write request; held until cpu_ack
- cpu_addr  in  AW  — CPU target register
- cpu_data  in  DW  — CPU write data
- cpu_ack  out  1  — one-CLK completion pulse
- int_req / int_addr / int_data / int_ack  — internal port; same widths and rules as CPU port
- phi_keep  out  1  — 1: cells keep their value; 0: write window
- reg_en  out  NREGS  — one-hot load enable; nonzero only while phi_keep=0
- reg_d  out  DW  — shared write data to all cells
- reg_res  out  1  — bank reset, active high
- addr_err  out  1  — one-CLK pulse when a granted address is >= NREGS

## Operation
- Phase counter pc counts 0..2*DIV-1 and wraps. phi_keep=0 for pc<DIV and 1 otherwise, registered.
- Arbitration happens only at pc==2*DIV-1, so the grant is valid for the entire next window. Candidates are requesters with req=1 at that edge.
- Priority: CPU wins over internal. Exception: the internal port wins when the fairness counter is active (see Configuration).
- On grant, addr and data are latched into the grant register. Later changes on that port's addr, data or req are ignored until ack.
- During the window: reg_d = latched data; reg_en = one-hot of latched addr. If addr >= NREGS, reg_en stays 0.
- At pc==DIV-1 (last window cycle), the granted port's ack pulses for one CLK. addr_err pulses with it if the address was out of range. The grant then clears.
- Without a grant, reg_en=0 and reg_d holds its last value.
- reg_res rises asynchronously with n_RES low. It stays 1 until the first wrap of pc after reset release (2*DIV CLK), then drops to 0. No writes are granted while reg_res=1.
- A port that drops req before the arbitration edge is simply not considered. Withdrawal is legal.
- A requester must keep req=1 through its ack cycle and deassert it after. If req is still 1 at the next arbitration edge, that counts as a new request.

## Timing
- Reset values: pc=0, phi_keep=1, reg_en=0, reg_d=0, cpu_ack=0, int_ack=0, addr_err=0, reg_res=1, grant cleared.
- First arbitration edge after release is at the pc==2*DIV-1 edge, where reg_res drops. The first write window follows.
- Latency from req (sampled) to ack is at most 3*DIV CLK with no contention.
- Throughput is one write per 2*DIV CLK.
- If both ports request at the same edge, the loser is served in the next period when it is still requesting.
- Reset mid-window: outputs return to reset values immediately and no ack is issued. The requester must re-present its request.
- reg_en and phi_keep=0 are asserted in the same cycles. No reg_en bit is ever 1 while phi_keep=1.

## Configuration
- REG_WRITE_SCHED_FAIR_EN defined: a 2-bit counter increments each time the CPU wins while int_req=1. At value 3, the next arbitration grants the internal port and the counter resets to 0. The counter also resets to 0 on any internal grant.
- Undefined: strict CPU priority. The internal port can starve.

## Structure
- Shared package reg_sched_pkg holds:
  - port-select enum: NONE, CPU, INT
  - DIV range constants
  - fairness threshold constant, value 3
- Sub-module phase_gen contains pc and phi_keep generation and exports the arb_edge, win_last and wrap strobes. Arbitration, grant latch and output decode stay in the top module.

## Test plan
- Reset release, DIV=2: reg_res=1 for 4 CLK after n_RES rises. phi_keep pattern is 0,0,1,1 repeating after that.
- Single CPU write of addr=5, data=0xA7: reg_en=0x20 and reg_d=0xA7 for both window cycles. cpu_ack pulses on the second window cycle.
- Simultaneous CPU (addr 1) and internal (addr 2) requests: CPU is written first. The internal write follows in the next period, and int_ack comes 4 CLK after cpu_ack.
- Continuous CPU requests with int_req held, FAIR_EN defined: the grant order is C,C,C,I. With the macro undefined, int_ack never asserts.
- Out-of-range write, NREGS=6, addr=7: reg_en stays 0 for the whole window. cpu_ack and addr_err pulse together.
- n_RES pulled low during a write window: reg_en goes to 0, phi_keep to 1 and reg_res to 1 in the same cycle. No ack is issued.
